// File: rtl/xadc_multichannel_packetizer.sv
// Multichannel XADC snapshot packetizer: captures all enabled channels at once
// and emits type, seq, mask, sample bytes and XOR checksum as a framed stream.
module xadc_multichannel_packetizer #(
    parameter int          NUM_CHANNELS = 2,
    parameter int          IN_WIDTH     = 16,
    parameter int          SAMPLE_LSB   = 4,
    parameter int          SAMPLE_WIDTH = 12,
    parameter logic [7:0]  PACKET_TYPE  = 8'h01
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CHANNELS-1:0]        channel_enable,
    input  logic [NUM_CHANNELS*IN_WIDTH-1:0] in_tdata,
    input  logic [NUM_CHANNELS-1:0]        in_tvalid,
    output logic [NUM_CHANNELS-1:0]        in_tready,
    output logic [7:0]                     out_tdata,
    output logic                           out_tvalid,
    input  logic                           out_tready,
    output logic                           out_tlast,
    output logic [7:0]                     seq_num,
    output logic                           busy
);

    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [2:0] {
        IDLE, HDR, SEQ, MASK, SAMPLE_HI, SAMPLE_LO, CSUM
    } state_t;

    state_t                  state;
    logic [SAMPLE_WIDTH-1:0] samp_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [CW-1:0]           ch_q;
    logic [7:0]              csum_q;
    logic [7:0]              seq_q;

    logic                    all_ready;
    logic                    accept;
    logic [CW-1:0]           first_ch;
    logic [CW-1:0]           next_ch;
    logic                    has_next;
    logic [7:0]              mask_byte;
    logic                    unused_bits;

    function automatic logic [7:0] hi_byte(input logic [SAMPLE_WIDTH-1:0] s);
        logic [15:0] e;
        e = '0;
        e[SAMPLE_WIDTH-1:0] = s;
        return e[15:8];
    endfunction

    function automatic logic [7:0] lo_byte(input logic [SAMPLE_WIDTH-1:0] s);
        return s[7:0];
    endfunction

    assign all_ready = (channel_enable != '0) &&
                       ((in_tvalid & channel_enable) == channel_enable);
    assign in_tready = (state == IDLE && all_ready) ? channel_enable : '0;
    assign accept    = out_tvalid & out_tready;
    assign busy      = (state != IDLE);
    assign seq_num   = seq_q;
    assign unused_bits = ^in_tdata;

    always_comb begin
        mask_byte = '0;
        mask_byte[NUM_CHANNELS-1:0] = mask_q;
    end

    // Lowest set mask bit overall, and lowest set bit above the current channel.
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_ch = CW'(i);
                if (i > int'(ch_q)) begin
                    next_ch  = CW'(i);
                    has_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            seq_q      <= '0;
            mask_q     <= '0;
            ch_q       <= '0;
            csum_q     <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) samp_q[i] <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (all_ready) begin
                        for (int i = 0; i < NUM_CHANNELS; i++)
                            samp_q[i] <= in_tdata[i*IN_WIDTH+SAMPLE_LSB +: SAMPLE_WIDTH];
                        mask_q     <= channel_enable;
                        csum_q     <= '0;
                        out_tdata  <= PACKET_TYPE;
                        out_tvalid <= 1'b1;
                        out_tlast  <= 1'b0;
                        state      <= HDR;
                    end
                end
                HDR: if (accept) begin
                    csum_q    <= csum_q ^ out_tdata;
                    out_tdata <= seq_q;
                    state     <= SEQ;
                end
                SEQ: if (accept) begin
                    csum_q    <= csum_q ^ out_tdata;
                    out_tdata <= mask_byte;
                    state     <= MASK;
                end
                MASK: if (accept) begin
                    csum_q    <= csum_q ^ out_tdata;
                    ch_q      <= first_ch;
                    out_tdata <= hi_byte(samp_q[first_ch]);
                    state     <= SAMPLE_HI;
                end
                SAMPLE_HI: if (accept) begin
                    csum_q    <= csum_q ^ out_tdata;
                    out_tdata <= lo_byte(samp_q[ch_q]);
                    state     <= SAMPLE_LO;
                end
                SAMPLE_LO: if (accept) begin
                    csum_q <= csum_q ^ out_tdata;
                    if (has_next) begin
                        ch_q      <= next_ch;
                        out_tdata <= hi_byte(samp_q[next_ch]);
                        state     <= SAMPLE_HI;
                    end else begin
                        out_tdata <= csum_q ^ out_tdata;
                        out_tlast <= 1'b1;
                        state     <= CSUM;
                    end
                end
                CSUM: if (accept) begin
                    seq_q      <= seq_q + 8'd1;
                    out_tdata  <= '0;
                    out_tvalid <= 1'b0;
                    out_tlast  <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_multichannel_packetizer.sv
// Directed bench for xadc_multichannel_packetizer with a byte-stream model.
module tb_xadc_multichannel_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  channel_enable;
    logic [31:0] in_tdata;
    logic [1:0]  in_tvalid;
    logic [1:0]  in_tready;
    logic [7:0]  out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tlast;
    logic [7:0]  seq_num;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [1:0]  mask_m;
    logic [11:0] samp_m [2];
    logic [7:0]  seq_m;

    xadc_multichannel_packetizer dut (
        .clk(clk), .rst(rst), .channel_enable(channel_enable),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tlast(out_tlast), .seq_num(seq_num), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after capture.
    task automatic capture(input logic [1:0] en, input logic [1:0] vld,
                           input logic [15:0] d0, input logic [15:0] d1);
        channel_enable = en;
        in_tvalid      = vld;
        in_tdata       = {d1, d0};
        #1;
        chk("in_tready", in_tready, en);
        @(negedge clk);
        in_tvalid = 2'b00;
        chk("first_valid", out_tvalid, 1);
        chk("first_byte", out_tdata, 8'h01);
        chk("busy", busy, 1);
        chk("first_tlast", out_tlast, 0);
        mask_m    = en;
        samp_m[0] = d0[15:4];
        samp_m[1] = d1[15:4];
    endtask

    task automatic run_packet(input bit rnd);
        logic [7:0] exp[$];
        logic [7:0] x;
        logic [7:0] held;
        int idx;
        bit stalled;
        exp.push_back(8'h01);
        exp.push_back(seq_m);
        exp.push_back({6'b0, mask_m});
        for (int i = 0; i < 2; i++) begin
            if (mask_m[i]) begin
                exp.push_back({4'h0, samp_m[i][11:8]});
                exp.push_back(samp_m[i][7:0]);
            end
        end
        x = 8'h00;
        foreach (exp[k]) x ^= exp[k];
        exp.push_back(x);
        idx = 0;
        stalled = 1'b0;
        held = 8'h00;
        for (int cyc = 0; cyc < 200 && idx < exp.size(); cyc++) begin
            if (stalled) chk("stall_hold", out_tdata, held);
            if (!rnd) chk("tvalid_cont", out_tvalid, 1);
            out_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_tvalid && out_tready) begin
                chk("byte", out_tdata, exp[idx]);
                chk("tlast", out_tlast, (idx == exp.size() - 1));
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = out_tvalid;
            end
            held = out_tdata;
            @(negedge clk);
        end
        chk("pkt_len", idx, exp.size());
        chk("idle_after", out_tvalid, 0);
        seq_m = seq_m + 8'd1;
        chk("seq_num", seq_num, seq_m);
    endtask

    initial begin
        rst = 1'b0;
        channel_enable = 2'b00;
        in_tdata = '0;
        in_tvalid = 2'b00;
        out_tready = 1'b0;
        seq_m = 8'h00;
        #1;
        chk("rst_tvalid", out_tvalid, 0);
        chk("rst_tlast", out_tlast, 0);
        chk("rst_tdata", out_tdata, 0);
        chk("rst_seq", seq_num, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tready", in_tready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Both channels, no backpressure
        capture(2'b11, 2'b11, 16'hABC0, 16'h1230);
        run_packet(1'b0);

        // Only ch1 enabled and valid
        capture(2'b10, 2'b10, 16'h5550, 16'hFFF0);
        run_packet(1'b0);

        // Empty mask accepts nothing
        channel_enable = 2'b00;
        in_tvalid = 2'b11;
        repeat (2) begin
            #1;
            chk("mask0_tready", in_tready, 0);
            chk("mask0_busy", busy, 0);
            @(negedge clk);
        end

        // ch0 withheld: no ready until all enabled channels are valid
        channel_enable = 2'b11;
        in_tvalid = 2'b10;
        repeat (3) begin
            #1;
            chk("wait_tready", in_tready, 0);
            chk("wait_busy", busy, 0);
            @(negedge clk);
        end
        capture(2'b11, 2'b11, 16'h0010, 16'hF000);
        run_packet(1'b1);

        // Mask change mid-packet only affects the next packet
        capture(2'b11, 2'b11, 16'h7A50, 16'h0C30);
        channel_enable = 2'b01;
        run_packet(1'b1);
        capture(2'b01, 2'b01, 16'h9870, 16'h4440);
        run_packet(1'b0);

        // Full sequence wrap
        for (int n = 0; n < 256; n++) begin
            capture(2'b01, 2'b01, 16'($urandom), 16'($urandom));
            run_packet(n[0]);
        end

        // Reset while presenting SAMPLE_LO
        capture(2'b11, 2'b11, 16'h3C50, 16'hA5A0);
        out_tready = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_lo", out_tdata, 8'hC5);
        rst = 1'b0;
        #1;
        chk("abort_tvalid", out_tvalid, 0);
        chk("abort_tlast", out_tlast, 0);
        chk("abort_seq", seq_num, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        seq_m = 8'h00;
        @(negedge clk);
        capture(2'b11, 2'b11, 16'h0FF0, 16'h8010);
        run_packet(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
